tft_draw_arbiter: RTL and testbench

- Parametrised arbiter that shares the single tft_spi transmitter among NUM_CLIENTS drawing engines (init, scene, player, future HUD/score).
- Replaces the hard-wired init→scene→player enable chain with request-driven, one-hot enable grants; fixed-priority or round-robin mode.
- Muxes the granted client's data/dc/transmit onto the SPI input and handles per-client busy handshake with a stuck-client timeout.

---
 rtl/tft_pkg.sv | 18 +
 rtl/tft_draw_arbiter_if.sv | 41 ++++
 rtl/tft_rr_picker.sv | 33 +++
 rtl/tft_draw_arbiter.sv | 133 +++++++++++++
 tb/tb_tft_draw_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/tft_pkg.sv
// Shared TFT drawing types: arbiter FSM states, default SPI byte width
// and the fixed client slot assignments used by the drawing engines.
package tft_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        HOLD      = 2'd2,
        GAP       = 2'd3
    } state_t;

    localparam int TFT_DATA_W = 8;

    localparam int CLIENT_INIT   = 0;
    localparam int CLIENT_SCENE  = 1;
    localparam int CLIENT_PLAYER = 2;

endpackage

// File: rtl/tft_draw_arbiter_if.sv
// Bus bundle between the drawing clients, the arbiter and tft_spi.
// master: client/SPI side that drives requests and data.
// slave : arbiter side that returns grants and the muxed SPI input.
//
// Handshake: a client holds req high until it is done. The arbiter answers
// with a one-hot enable; the enabled client must raise client_busy within
// BUSY_TIMEOUT cycles and keep it high for the whole transfer. Lowering
// client_busy ends the grant. spi_busy must be low before a new grant.
interface tft_draw_arbiter_if
    import tft_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    parameter int DATA_W      = TFT_DATA_W
);
    localparam int ID_W = $clog2(NUM_CLIENTS);

    logic [NUM_CLIENTS-1:0]        req;
    logic [NUM_CLIENTS-1:0]        client_busy;
    logic [NUM_CLIENTS*DATA_W-1:0] client_data;
    logic [NUM_CLIENTS-1:0]        client_dc;
    logic [NUM_CLIENTS-1:0]        client_transmit;
    logic                          spi_busy;
    logic [NUM_CLIENTS-1:0]        enable;
    logic [DATA_W-1:0]             spi_data;
    logic                          spi_dc;
    logic                          spi_transmit;
    logic [ID_W-1:0]               grant_id;
    logic                          active;
    logic                          timeout_err;

    modport master (
        output req, client_busy, client_data, client_dc, client_transmit, spi_busy,
        input  enable, spi_data, spi_dc, spi_transmit, grant_id, active, timeout_err
    );

    modport slave (
        input  req, client_busy, client_data, client_dc, client_transmit, spi_busy,
        output enable, spi_data, spi_dc, spi_transmit, grant_id, active, timeout_err
    );

endinterface

// File: rtl/tft_rr_picker.sv
// Combinational winner selection over a request vector. In fixed mode the
// lowest index wins; in round-robin mode the search starts one past ptr and
// wraps at NUM_CLIENTS-1 -> 0.
module tft_rr_picker #(
    parameter int NUM_CLIENTS = 3,
    parameter int ID_W        = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [ID_W-1:0]        ptr,
    input  logic                   rr_mode,
    output logic [ID_W-1:0]        winner,
    output logic                   valid
);

    logic [ID_W-1:0] idx;
    int              start;

    // Scan from the start position and keep the first requester found.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        start  = rr_mode ? (int'(ptr) + 1) : 0;
        for (int off = 0; off < NUM_CLIENTS; off++) begin
            idx = ID_W'((start + off) % NUM_CLIENTS);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tft_draw_arbiter.sv
// Shares one tft_spi transmitter among NUM_CLIENTS drawing engines.
// Request-driven one-hot grants, fixed priority or round robin, with a
// timeout that revokes a grant whose client never raises busy.
// Optional macro DRAW_ARB_ONESHOT_EN: client 0 (tft_init) is granted only
// once per reset; a timed-out grant does not count as its one shot.
module tft_draw_arbiter
    import tft_pkg::*;
#(
    parameter int NUM_CLIENTS  = 3,
    parameter int DATA_W       = TFT_DATA_W,
    parameter int ROUND_ROBIN  = 0,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    tft_draw_arbiter_if.slave   bus,
    output state_t              state
);

    localparam int ID_W  = $clog2(NUM_CLIENTS);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    state_t                 state_q;
    logic [NUM_CLIENTS-1:0] enable_q;
    logic [ID_W-1:0]        grant_id_q;
    logic                   timeout_q;
    logic [ID_W-1:0]        ptr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_CLIENTS-1:0] mask;

    logic [ID_W-1:0]        pick_id;
    logic                   pick_valid;
    logic [NUM_CLIENTS-1:0] pick_onehot;
    logic                   g_busy;

    tft_rr_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .ID_W        (ID_W)
    ) u_picker (
        .req     (bus.req & ~mask),
        .ptr     (ptr_q),
        .rr_mode (ROUND_ROBIN != 0),
        .winner  (pick_id),
        .valid   (pick_valid)
    );

    assign pick_onehot = NUM_CLIENTS'(1) << pick_id;
    // Busy of the granted client only; zero whenever nothing is granted.
    assign g_busy      = |(bus.client_busy & enable_q);

    // Grant FSM: IDLE -> WAIT_BUSY -> HOLD -> GAP -> IDLE, timeout skips HOLD.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            enable_q   <= '0;
            grant_id_q <= '0;
            timeout_q  <= 1'b0;
            ptr_q      <= ID_W'(NUM_CLIENTS - 1);
            cnt_q      <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!bus.spi_busy && pick_valid) begin
                        enable_q   <= pick_onehot;
                        grant_id_q <= pick_id;
                        cnt_q      <= '0;
                        state_q    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (g_busy) begin
                        state_q <= HOLD;
                    end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        enable_q  <= '0;
                        timeout_q <= 1'b1;
                        state_q   <= GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!g_busy) begin
                        enable_q <= '0;
                        ptr_q    <= grant_id_q;
                        state_q  <= GAP;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    enable_q <= '0;
                end
            endcase
        end
    end

`ifdef DRAW_ARB_ONESHOT_EN
    // Retire client 0 after its first normally completed grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mask <= '0;
        end else if (state_q == HOLD && !g_busy && enable_q[0]) begin
            mask[0] <= 1'b1;
        end
    end
`else
    assign mask = '0;
`endif

    // Output mux: AND-OR over the one-hot grant, so idle drives all zeros.
    always_comb begin
        bus.spi_data     = '0;
        bus.spi_dc       = 1'b0;
        bus.spi_transmit = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (enable_q[i]) begin
                bus.spi_data     = bus.spi_data | bus.client_data[i*DATA_W +: DATA_W];
                bus.spi_dc       = bus.spi_dc | bus.client_dc[i];
                bus.spi_transmit = bus.spi_transmit | bus.client_transmit[i];
            end
        end
    end

    assign bus.enable      = enable_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.active      = |enable_q;
    assign bus.timeout_err = timeout_q;
    assign state           = state_q;

endmodule

// File: tb/tb_tft_draw_arbiter.sv
// Directed bench for tft_draw_arbiter: one fixed-priority and one
// round-robin instance sharing clock and reset.
module tb_tft_draw_arbiter;
    import tft_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    state_t st_fx;
    state_t st_rr;
    int     total = 0;
    int     bad   = 0;
    int     exp_order [5] = '{0, 1, 2, 0, 1};
    logic [2:0] exp_oh;

    tft_draw_arbiter_if #(.NUM_CLIENTS(3), .DATA_W(8)) bus_fx ();
    tft_draw_arbiter_if #(.NUM_CLIENTS(3), .DATA_W(8)) bus_rr ();

    tft_draw_arbiter #(
        .NUM_CLIENTS(3), .DATA_W(8), .ROUND_ROBIN(0), .BUSY_TIMEOUT(15)
    ) dut_fx (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_fx),
        .state (st_fx)
    );

    tft_draw_arbiter #(
        .NUM_CLIENTS(3), .DATA_W(8), .ROUND_ROBIN(1), .BUSY_TIMEOUT(15)
    ) dut_rr (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_rr),
        .state (st_rr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus_fx.req = '0; bus_fx.client_busy = '0; bus_fx.client_data = '0;
        bus_fx.client_dc = '0; bus_fx.client_transmit = '0; bus_fx.spi_busy = 1'b0;
        bus_rr.req = '0; bus_rr.client_busy = '0; bus_rr.client_data = '0;
        bus_rr.client_dc = '0; bus_rr.client_transmit = '0; bus_rr.spi_busy = 1'b0;

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        chk("rst_enable", 32'(bus_fx.enable), 32'h0);
        chk("rst_grant_id", 32'(bus_fx.grant_id), 32'h0);
        chk("rst_active", 32'(bus_fx.active), 32'h0);
        chk("rst_timeout", 32'(bus_fx.timeout_err), 32'h0);
        chk("rst_spi_data", 32'(bus_fx.spi_data), 32'h0);
        chk("rst_state", 32'(st_fx), 32'(IDLE));
        chk("rst_rr_enable", 32'(bus_rr.enable), 32'h0);
        rst = 1'b1;
        tick();

        // Fixed priority: req 110 -> client 1 granted one cycle later
        bus_fx.client_data = {8'h3C, 8'hA5, 8'h11};
        bus_fx.req = 3'b110;
        tick();
        chk("fx_grant_en", 32'(bus_fx.enable), 32'h2);
        chk("fx_grant_id", 32'(bus_fx.grant_id), 32'h1);
        chk("fx_active", 32'(bus_fx.active), 32'h1);
        chk("fx_wait_state", 32'(st_fx), 32'(WAIT_BUSY));
        chk("fx_mux_data", 32'(bus_fx.spi_data), 32'hA5);
        bus_fx.client_busy = 3'b010;
        tick();
        chk("fx_hold_state", 32'(st_fx), 32'(HOLD));
        chk("fx_hold_en", 32'(bus_fx.enable), 32'h2);

        // Mux isolation
        bus_fx.client_dc = 3'b010;
        bus_fx.client_transmit = 3'b010;
        #1;
        chk("mux_dc_on", 32'(bus_fx.spi_dc), 32'h1);
        chk("mux_tx_on", 32'(bus_fx.spi_transmit), 32'h1);
        bus_fx.client_dc = 3'b101;
        bus_fx.client_transmit = 3'b101;
        bus_fx.client_data = {8'hFF, 8'hA5, 8'hEE};
        #1;
        chk("mux_dc_other", 32'(bus_fx.spi_dc), 32'h0);
        chk("mux_tx_other", 32'(bus_fx.spi_transmit), 32'h0);
        chk("mux_data_other", 32'(bus_fx.spi_data), 32'hA5);

        // Long hold ignores other requests
        repeat (18) tick();
        chk("fx_long_hold_en", 32'(bus_fx.enable), 32'h2);
        chk("fx_long_hold_st", 32'(st_fx), 32'(HOLD));

        // Release -> GAP, IDLE, then client 2
        bus_fx.client_busy = 3'b000;
        bus_fx.req = 3'b100;
        tick();
        chk("fx_gap_en", 32'(bus_fx.enable), 32'h0);
        chk("fx_gap_active", 32'(bus_fx.active), 32'h0);
        chk("fx_gap_state", 32'(st_fx), 32'(GAP));
        chk("fx_gap_id_hold", 32'(bus_fx.grant_id), 32'h1);
        chk("idle_spi_data", 32'(bus_fx.spi_data), 32'h0);
        chk("idle_spi_dc", 32'(bus_fx.spi_dc), 32'h0);
        chk("idle_spi_tx", 32'(bus_fx.spi_transmit), 32'h0);
        tick();
        chk("fx_idle_en", 32'(bus_fx.enable), 32'h0);
        chk("fx_idle_state", 32'(st_fx), 32'(IDLE));
        tick();
        chk("fx_c2_en", 32'(bus_fx.enable), 32'h4);
        chk("fx_c2_id", 32'(bus_fx.grant_id), 32'h2);

        // Timeout: client 2 never busy, revoked after 15 cycles
        repeat (14) tick();
        chk("to_pre_en", 32'(bus_fx.enable), 32'h4);
        chk("to_pre_err", 32'(bus_fx.timeout_err), 32'h0);
        tick();
        chk("to_en", 32'(bus_fx.enable), 32'h0);
        chk("to_err", 32'(bus_fx.timeout_err), 32'h1);
        chk("to_state", 32'(st_fx), 32'(GAP));
        tick();
        chk("to_err_clear", 32'(bus_fx.timeout_err), 32'h0);
        chk("to_idle_state", 32'(st_fx), 32'(IDLE));
        tick();
        chk("to_regrant_en", 32'(bus_fx.enable), 32'h4);

        // Busy arriving on the timeout cycle wins
        repeat (14) tick();
        bus_fx.client_busy = 3'b100;
        tick();
        chk("tie_state", 32'(st_fx), 32'(HOLD));
        chk("tie_err", 32'(bus_fx.timeout_err), 32'h0);
        chk("tie_en", 32'(bus_fx.enable), 32'h4);

        // spi_busy held through GAP delays the next grant
        bus_fx.client_busy = 3'b000;
        bus_fx.req = 3'b001;
        bus_fx.spi_busy = 1'b1;
        tick();
        chk("sb_gap_state", 32'(st_fx), 32'(GAP));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sb_block_en", 32'(bus_fx.enable), 32'h0);
        end
        bus_fx.spi_busy = 1'b0;
        tick();
        chk("sb_release_en", 32'(bus_fx.enable), 32'h1);
        chk("sb_release_id", 32'(bus_fx.grant_id), 32'h0);
        bus_fx.client_busy = 3'b001;
        tick();
        bus_fx.client_busy = 3'b000;
        bus_fx.req = 3'b000;
        tick();
        tick();
        chk("c0_done_idle", 32'(st_fx), 32'(IDLE));

        // Client 0 asks again after a normal completion
        bus_fx.req = 3'b001;
`ifdef DRAW_ARB_ONESHOT_EN
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("oneshot_masked", 32'(bus_fx.enable), 32'h0);
        end
        bus_fx.req = 3'b000;
`else
        tick();
        chk("regrant_c0", 32'(bus_fx.enable), 32'h1);
        bus_fx.client_busy = 3'b001;
        tick();
        bus_fx.client_busy = 3'b000;
        bus_fx.req = 3'b000;
        tick();
        tick();
`endif

        // Round robin: req 111, each client busy 5 cycles
        bus_rr.req = 3'b111;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 3'b001 << exp_order[k];
            tick();
            chk("rr_grant_en", 32'(bus_rr.enable), 32'(exp_oh));
            chk("rr_grant_id", 32'(bus_rr.grant_id), 32'(exp_order[k]));
            bus_rr.client_busy = exp_oh;
            repeat (5) tick();
            chk("rr_hold_en", 32'(bus_rr.enable), 32'(exp_oh));
            chk("rr_hold_state", 32'(st_rr), 32'(HOLD));
            bus_rr.client_busy = 3'b000;
            tick();
            chk("rr_gap1_en", 32'(bus_rr.enable), 32'h0);
            tick();
            chk("rr_gap2_en", 32'(bus_rr.enable), 32'h0);
        end
        bus_rr.req = 3'b000;

        // Reset in the middle of a HOLD
        bus_fx.req = 3'b010;
        tick();
        chk("mr_grant_en", 32'(bus_fx.enable), 32'h2);
        bus_fx.client_busy = 3'b010;
        tick();
        chk("mr_hold_state", 32'(st_fx), 32'(HOLD));
        rst = 1'b0;
        tick();
        chk("mr_rst_en", 32'(bus_fx.enable), 32'h0);
        chk("mr_rst_state", 32'(st_fx), 32'(IDLE));
        chk("mr_rst_id", 32'(bus_fx.grant_id), 32'h0);
        chk("mr_rst_active", 32'(bus_fx.active), 32'h0);
        rst = 1'b1;
        bus_fx.client_busy = 3'b000;
        bus_fx.req = 3'b001;
        tick();
        chk("mr_c0_again_en", 32'(bus_fx.enable), 32'h1);
        chk("mr_c0_again_id", 32'(bus_fx.grant_id), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
